// File: rtl/enemy_formation.sv
// ROWS x COLS invader formation: alive bitmap, edge-aware march with speed-up,
// shot-to-cell resolution and zero-latency per-pixel sprite lookup for the VGA mapper.
module enemy_formation #(
  parameter int ROWS        = 3,
  parameter int COLS        = 7,
  parameter int CELL_W      = 73,
  parameter int CELL_H      = 50,
  parameter int SPR_W       = 49,
  parameter int SPR_H       = 43,
  parameter int STEP_X      = 1,
  parameter int DROP_Y      = 8,
  parameter int SCREEN_W    = 640,
  parameter int FLOOR_Y     = 356,
  parameter int SPEED_SHIFT = 2
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             Start,
  input  logic                             frame_tick,
  input  logic                             shot_valid,
  input  logic [9:0]                       shot_x,
  input  logic [9:0]                       shot_y,
  input  logic [9:0]                       DrawX,
  input  logic [9:0]                       DrawY,
  output logic                             enemy_on,
  output logic [$clog2(ROWS)-1:0]          enemy_row,
  output logic [$clog2(COLS)-1:0]          enemy_col,
  output logic                             hit,
  output logic [$clog2(ROWS)-1:0]          hit_row,
  output logic [$clog2(COLS)-1:0]          hit_col,
  output logic [$clog2(ROWS*COLS+1)-1:0]   alive_count,
  output logic signed [10:0]               form_x,
  output logic [9:0]                       form_y,
  output logic                             cleared,
  output logic                             lost
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {IDLE, MARCH_R, MARCH_L, CLEARED, LOST} state_t;

  state_t          state, state_n;
  logic [N-1:0]    alive, alive_n;
  logic [AW-1:0]   count_n, tick_cnt, tick_n;
  logic signed [10:0] fx_n;
  logic [9:0]      fy_n;
  logic            hit_n, cleared_n, lost_n, drop;
  logic [RW-1:0]   hr_n, lr;
  logic [CW-1:0]   hc_n, lc, rc;
  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;
  int              left_e, right_e;

  // Returns {inside_alive_sprite, row, col}; shared by hit resolution and rendering.
  function automatic logic [RW+CW:0] locate(input logic [9:0] px, input logic [9:0] py,
                                            input logic signed [10:0] fx, input logic [9:0] fy,
                                            input logic [N-1:0] al);
    int dx, dy, c, r;
    logic ok;
    logic [IW-1:0] idx;
    dx = int'(px) - int'(fx);
    dy = int'(py) - int'(fy);
    ok = (dx >= 0) && (dx < COLS*CELL_W) && (dy >= 0) && (dy < ROWS*CELL_H) &&
         ((dx % CELL_W) < SPR_W) && ((dy % CELL_H) < SPR_H);
    c = ok ? dx / CELL_W : 0;
    r = ok ? dy / CELL_H : 0;
    idx = IW'(r*COLS + c);
    ok = ok && al[idx];
    return ok ? {1'b1, RW'(r), CW'(c)} : '0;
  endfunction

  logic [RW+CW:0] shot_loc, draw_loc;
  logic           shot_ok;
  logic [RW-1:0]  shot_row;
  logic [CW-1:0]  shot_col;

  assign shot_loc = locate(shot_x, shot_y, form_x, form_y, alive);
  assign draw_loc = locate(DrawX, DrawY, form_x, form_y, alive);
  assign shot_ok  = shot_loc[RW+CW];
  assign shot_row = shot_loc[RW+CW-1:CW];
  assign shot_col = shot_loc[CW-1:0];

  always_comb begin
    {enemy_on, enemy_row, enemy_col} = (state == IDLE) ? '0 : draw_loc;
  end

  // Bounding box of the surviving enemies drives edge and floor tests.
  always_comb begin
    col_any = '0;
    row_any = '0;
    lc = '0;
    rc = '0;
    lr = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (alive[IW'(r*COLS + c)]) begin
          col_any[CW'(c)] = 1'b1;
          row_any[RW'(r)] = 1'b1;
        end
    for (int c = COLS-1; c >= 0; c--) if (col_any[CW'(c)]) lc = CW'(c);
    for (int c = 0; c < COLS; c++)    if (col_any[CW'(c)]) rc = CW'(c);
    for (int r = 0; r < ROWS; r++)    if (row_any[RW'(r)]) lr = RW'(r);
  end

  always_comb begin
    state_n   = state;
    alive_n   = alive;
    count_n   = alive_count;
    fx_n      = form_x;
    fy_n      = form_y;
    tick_n    = tick_cnt;
    hit_n     = 1'b0;
    hr_n      = hit_row;
    hc_n      = hit_col;
    cleared_n = cleared;
    lost_n    = lost;
    drop      = 1'b0;
    left_e    = int'(form_x) + int'(lc)*CELL_W;
    right_e   = int'(form_x) + int'(rc)*CELL_W + SPR_W - 1;
    case (state)
      IDLE, CLEARED, LOST: begin
        if (Start) begin
          state_n   = MARCH_R;
          alive_n   = '1;
          count_n   = AW'(N);
          fx_n      = '0;
          fy_n      = '0;
          tick_n    = '0;
          hr_n      = '0;
          hc_n      = '0;
          cleared_n = 1'b0;
          lost_n    = 1'b0;
        end
      end
      default: begin
        // Shot is resolved against the current (pre-step) position.
        if (shot_valid && shot_ok) begin
          alive_n[IW'(int'(shot_row)*COLS + int'(shot_col))] = 1'b0;
          count_n = alive_count - AW'(1);
          hit_n   = 1'b1;
          hr_n    = shot_row;
          hc_n    = shot_col;
        end
        if (frame_tick) begin
          if (tick_cnt >= (alive_count >> SPEED_SHIFT)) begin
            tick_n = '0;
            if (state == MARCH_R) begin
              if (right_e + STEP_X > SCREEN_W - 1) begin
                drop    = 1'b1;
                state_n = MARCH_L;
              end else begin
                fx_n = form_x + 11'(STEP_X);
              end
            end else begin
              if (left_e - STEP_X < 0) begin
                drop    = 1'b1;
                state_n = MARCH_R;
              end else begin
                fx_n = form_x - 11'(STEP_X);
              end
            end
            if (drop) begin
              fy_n = form_y + 10'(DROP_Y);
              if (int'(fy_n) + int'(lr)*CELL_H + SPR_H - 1 >= FLOOR_Y) begin
                state_n = LOST;
                lost_n  = 1'b1;
              end
            end
          end else begin
            tick_n = tick_cnt + AW'(1);
          end
        end
        if (count_n == '0) begin
          state_n   = CLEARED;
          cleared_n = 1'b1;
          lost_n    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      alive       <= '1;
      alive_count <= AW'(N);
      form_x      <= '0;
      form_y      <= '0;
      tick_cnt    <= '0;
      hit         <= 1'b0;
      hit_row     <= '0;
      hit_col     <= '0;
      cleared     <= 1'b0;
      lost        <= 1'b0;
    end else begin
      state       <= state_n;
      alive       <= alive_n;
      alive_count <= count_n;
      form_x      <= fx_n;
      form_y      <= fy_n;
      tick_cnt    <= tick_n;
      hit         <= hit_n;
      hit_row     <= hr_n;
      hit_col     <= hc_n;
      cleared     <= cleared_n;
      lost        <= lost_n;
    end
  end

endmodule
